// File: rtl/q_pulse_monitor_if.sv
// q_pulse_monitor_if
// Groups the control inputs and status outputs of q_pulse_monitor.
//   en, din, clr          : monitor enable, sampled q level, statistics clear
//   filt                  : filtered level of din
//   rise_pulse/fall_pulse : one-cycle filtered edge strobes
//   rise_count, sat       : saturating rising-edge count and its sticky flag
//   high_len, len_valid   : last completed high-pulse length and update strobe
//   thresh_hit            : rise_count has reached the threshold
// master drives the inputs (upstream/bench); slave is the monitor itself.
interface q_pulse_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             din;
  logic             clr;
  logic             filt;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_count;
  logic             sat;
  logic [CNT_W-1:0] high_len;
  logic             len_valid;
  logic             thresh_hit;

  modport master (
    output en, din, clr,
    input  filt, rise_pulse, fall_pulse, rise_count, sat, high_len, len_valid, thresh_hit
  );

  modport slave (
    input  en, din, clr,
    output filt, rise_pulse, fall_pulse, rise_count, sat, high_len, len_valid, thresh_hit
  );
endinterface

// File: rtl/q_pulse_monitor.sv
// q_pulse_monitor
// Watches the registered AND-gate flop output (din), debounces it with a
// four-state stability filter, strobes filtered rising/falling edges, counts
// rising edges (saturating, with sticky sat), measures each completed high
// pulse and flags when the rise count reaches THRESH.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : q_pulse_monitor_if.slave (en, din, clr in; status out)
module q_pulse_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8,
  parameter int THRESH        = 4
) (
  input logic              clk,
  input logic              rst_n,
  q_pulse_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    P_HIGH = 2'd1,
    S_HIGH = 2'd2,
    P_LOW  = 2'd3
  } state_t;

  localparam logic [3:0]       STABLE_V = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       run;
  logic [3:0]       run_nxt;
  logic             filt;
  logic             filt_nxt;
  logic             rise_evt;
  logic             fall_evt;

  logic             rise_pulse;
  logic             fall_pulse;
  logic             len_valid;
  logic             sat;
  logic [CNT_W-1:0] rise_count;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] len_cnt;

  // filter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOW;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  // filter next-state: a pending state needs STABLE_CYCLES agreeing samples
  // in a row; one disagreeing sample falls back to the settled level
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (bus.en) begin
      unique case (state)
        S_LOW: begin
          if (bus.din) begin
            if (STABLE_V == 4'd1) begin
              state_nxt = S_HIGH;
              run_nxt   = '0;
            end else begin
              state_nxt = P_HIGH;
              run_nxt   = 4'd1;
            end
          end
        end
        P_HIGH: begin
          if (bus.din) begin
            if (run + 4'd1 >= STABLE_V) begin
              state_nxt = S_HIGH;
              run_nxt   = '0;
            end else begin
              run_nxt = run + 4'd1;
            end
          end else begin
            state_nxt = S_LOW;
            run_nxt   = '0;
          end
        end
        S_HIGH: begin
          if (!bus.din) begin
            if (STABLE_V == 4'd1) begin
              state_nxt = S_LOW;
              run_nxt   = '0;
            end else begin
              state_nxt = P_LOW;
              run_nxt   = 4'd1;
            end
          end
        end
        P_LOW: begin
          if (!bus.din) begin
            if (run + 4'd1 >= STABLE_V) begin
              state_nxt = S_LOW;
              run_nxt   = '0;
            end else begin
              run_nxt = run + 4'd1;
            end
          end else begin
            state_nxt = S_HIGH;
            run_nxt   = '0;
          end
        end
        default: begin
          state_nxt = S_LOW;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // filter outputs: filt is high while settled high or pending a fall, so an
  // edge event is exactly a change of that decode across the clock edge
  always_comb begin
    filt     = (state == S_HIGH) || (state == P_LOW);
    filt_nxt = (state_nxt == S_HIGH) || (state_nxt == P_LOW);
    rise_evt = !filt && filt_nxt;
    fall_evt = filt && !filt_nxt;
  end

  // statistics register stage: pulses follow the filter edge; clr overrides
  // the statistics but leaves the in-progress length counter running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      len_valid  <= 1'b0;
      sat        <= 1'b0;
      rise_count <= '0;
      high_len   <= '0;
      len_cnt    <= '0;
    end else begin
      rise_pulse <= rise_evt;
      fall_pulse <= fall_evt;
      len_valid  <= fall_evt && !bus.clr;

      if (bus.en) begin
        if (rise_evt) begin
          len_cnt <= CNT_W'(1);
        end else if (filt && !fall_evt) begin
          len_cnt <= sat_inc(len_cnt);
        end
      end

      if (bus.clr) begin
        rise_count <= '0;
        sat        <= 1'b0;
        high_len   <= '0;
      end else begin
        if (rise_evt) begin
          rise_count <= sat_inc(rise_count);
          if (sat_inc(rise_count) == CNT_MAX) begin
            sat <= 1'b1;
          end
        end
        if (fall_evt) begin
          high_len <= len_cnt;
        end
      end
    end
  end

  generate
    if (THRESH == 0) begin : g_thr_always
      assign bus.thresh_hit = 1'b1;
    end else begin : g_thr_cmp
      assign bus.thresh_hit = (rise_count >= CNT_W'(THRESH));
    end
  endgenerate

  assign bus.filt       = filt;
  assign bus.rise_pulse = rise_pulse;
  assign bus.fall_pulse = fall_pulse;
  assign bus.rise_count = rise_count;
  assign bus.sat        = sat;
  assign bus.high_len   = high_len;
  assign bus.len_valid  = len_valid;

endmodule

// File: tb/tb_q_pulse_monitor.sv
// tb_q_pulse_monitor
// Scoreboard bench for q_pulse_monitor (STABLE_CYCLES=2, CNT_W=4, THRESH=3).
// Stimulus pushes the expected status snapshot for every edge event it
// provokes; a negedge monitor pops one entry whenever rise_pulse, fall_pulse
// or len_valid is seen and compares all status fields.
module tb_q_pulse_monitor;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  q_pulse_monitor_if #(.CNT_W(CNT_W)) bus();

  q_pulse_monitor #(
    .STABLE_CYCLES(2),
    .CNT_W        (CNT_W),
    .THRESH       (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic       rp;
    logic       fp;
    logic       lv;
    logic       filt;
    logic [3:0] cnt;
    logic       sat;
    logic [3:0] hl;
    logic       th;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic rp, input logic fp, input logic lv, input logic f,
                              input int c, input logic s, input int h, input logic t);
    exp_t e;
    e.rp   = rp;
    e.fp   = fp;
    e.lv   = lv;
    e.filt = f;
    e.cnt  = 4'(c);
    e.sat  = s;
    e.hl   = 4'(h);
    e.th   = t;
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (bus.rise_pulse || bus.fall_pulse || bus.len_valid)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: rise=%0b fall=%0b len_valid=%0b, none expected at %0t",
                 bus.rise_pulse, bus.fall_pulse, bus.len_valid, $time);
      end else begin
        e = sb.pop_front();
        check("ev_rise_pulse", bus.rise_pulse, e.rp);
        check("ev_fall_pulse", bus.fall_pulse, e.fp);
        check("ev_len_valid",  bus.len_valid,  e.lv);
        check("ev_filt",       bus.filt,       e.filt);
        check("ev_rise_count", bus.rise_count, e.cnt);
        check("ev_sat",        bus.sat,        e.sat);
        check("ev_high_len",   bus.high_len,   e.hl);
        check("ev_thresh_hit", bus.thresh_hit, e.th);
      end
    end
  end

  task automatic step(input logic d);
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.en  = 1'b1;
    bus.din = 1'b0;
    bus.clr = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_filt",       bus.filt,       0);
    check("rst_rise_pulse", bus.rise_pulse, 0);
    check("rst_fall_pulse", bus.fall_pulse, 0);
    check("rst_rise_count", bus.rise_count, 0);
    check("rst_sat",        bus.sat,        0);
    check("rst_high_len",   bus.high_len,   0);
    check("rst_len_valid",  bus.len_valid,  0);
    check("rst_thresh_hit", bus.thresh_hit, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single-sample glitch is rejected
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("glitch_filt",       bus.filt,       0);
    check("glitch_rise_count", bus.rise_count, 0);

    // clean 6-cycle pulse
    sb.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    sb.push_back(mk(0, 1, 1, 0, 1, 0, 6, 0));
    step(1'b1);
    check("clean_filt_lat1", bus.filt, 0);
    step(1'b1);
    check("clean_filt_rise", bus.filt, 1);
    repeat (4) step(1'b1);
    step(1'b0);
    check("clean_filt_hold", bus.filt, 1);
    step(1'b0);
    check("clean_filt_fall", bus.filt, 0);
    check("clean_fall_now",  bus.fall_pulse, 1);
    repeat (2) step(1'b0);

    // clear then 17 pulses: threshold and saturation
    bus.clr = 1'b1;
    step(1'b0);
    bus.clr = 1'b0;
    check("clr_rise_count", bus.rise_count, 0);
    check("clr_high_len",   bus.high_len,   0);
    for (int i = 1; i <= 17; i++) begin
      int c;
      c = (i > 15) ? 15 : i;
      sb.push_back(mk(1, 0, 0, 1, c, i >= 15, (i == 1) ? 0 : 3, c >= 3));
      sb.push_back(mk(0, 1, 1, 0, c, i >= 15, 3, c >= 3));
      repeat (3) step(1'b1);
      repeat (3) step(1'b0);
    end
    check("sat_rise_count", bus.rise_count, 15);
    check("sat_flag",       bus.sat,        1);
    check("sat_thresh",     bus.thresh_hit, 1);

    // clr coincident with the second pulse's rise
    sb.push_back(mk(1, 0, 0, 1, 15, 1, 3, 1));
    sb.push_back(mk(0, 1, 1, 0, 15, 1, 3, 1));
    repeat (3) step(1'b1);
    repeat (3) step(1'b0);
    sb.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 1, 1, 0, 0, 0, 3, 0));
    step(1'b1);
    bus.clr = 1'b1;
    step(1'b1);
    bus.clr = 1'b0;
    check("clrrise_filt",   bus.filt,       1);
    check("clrrise_count",  bus.rise_count, 0);
    check("clrrise_sat",    bus.sat,        0);
    check("clrrise_thresh", bus.thresh_hit, 0);
    step(1'b1);
    repeat (3) step(1'b0);

    // clr coincident with a completing fall
    sb.push_back(mk(1, 0, 0, 1, 1, 0, 3, 0));
    sb.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) step(1'b1);
    step(1'b0);
    bus.clr = 1'b1;
    step(1'b0);
    bus.clr = 1'b0;
    step(1'b0);

    // en hold while pending high with run=1
    step(1'b1);
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'(i % 2));
      check("enhold_filt", bus.filt, 0);
    end
    bus.en = 1'b1;
    sb.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    step(1'b1);
    check("enresume_filt", bus.filt, 1);
    repeat (3) step(1'b1);

    // async reset mid-pulse
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_filt",       bus.filt,       0);
    check("arst_fall_pulse", bus.fall_pulse, 0);
    check("arst_high_len",   bus.high_len,   0);
    check("arst_len_valid",  bus.len_valid,  0);
    check("arst_rise_count", bus.rise_count, 0);
    bus.din = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step(1'b0);
    check("arst_no_fall", bus.fall_pulse, 0);

    // fresh pulse after reset
    sb.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0));
    sb.push_back(mk(0, 1, 1, 0, 1, 0, 2, 0));
    repeat (2) step(1'b1);
    repeat (3) step(1'b0);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/q_pulse_monitor.md
Name: q_pulse_monitor

Overview:
- Downstream consumer of the registered AND-gate flop output (q) in the dff_andgate stage.
- Filters the q stream for stability and detects filtered rising and falling edges.
- Counts rising events and measures the length of each completed high pulse.
- Flags when the event count reaches a threshold; the status feeds later control logic.

Parameters:
- STABLE_CYCLES, 2, consecutive sampled cycles din must differ from filt before filt changes (legal range 1..15).
- CNT_W, 8, width of rise_count and high_len.
- THRESH, 4, rise_count value at or above which thresh_hit asserts (must be < 2^CNT_W).

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, 1 = monitor active; 0 = hold all state.
- din, input, 1, registered q from the upstream flop; already synchronous, no synchronizer.
- clr, input, 1, synchronous clear of statistics.
- filt, output, 1, filtered level of din.
- rise_pulse, output, 1, one-cycle pulse on filtered 0->1.
- fall_pulse, output, 1, one-cycle pulse on filtered 1->0.
- rise_count, output, CNT_W, saturating count of filtered rising edges.
- sat, output, 1, sticky; set when rise_count saturates.
- high_len, output, CNT_W, length in cycles of the last completed filtered high pulse (saturating).
- len_valid, output, 1, one-cycle pulse when high_len updates.
- thresh_hit, output, 1, rise_count >= THRESH.

Behaviour:
- Reset (rst_n=0, async): FSM=S_LOW, run counter=0, all outputs 0.
- Filter FSM states:
  - S_LOW: on din=1 go to P_HIGH with run=1; if STABLE_CYCLES=1, go directly to S_HIGH instead.
  - P_HIGH: din=1 increments run; when run reaches STABLE_CYCLES go to S_HIGH; din=0 returns to S_LOW with run=0.
  - S_HIGH: on din=1 no action; on din=0 go to P_LOW with run=1.
  - P_LOW: symmetric to P_HIGH; reaching STABLE_CYCLES goes to S_LOW; din=1 returns to S_HIGH with run=0.
- Filter timing:
  - din sampled differing from filt at edges k..k+S-1 (S=STABLE_CYCLES) toggles filt at edge k+S-1.
  - Filter latency is S edges.
  - A glitch shorter than S samples produces no filt change and no pulse.
- Edge pulses:
  - rise_pulse and fall_pulse are registered and asserted in the same cycle filt toggles.
  - Each is high for exactly one cycle.
- rise_count:
  - Increments on each rise_pulse.
  - At 2^CNT_W-1 it holds and sat sets (sticky until clr or reset).
- high_len:
  - An internal length counter loads 1 at the edge where filt rises and increments each cycle filt stays 1, saturating at 2^CNT_W-1.
  - At the edge where filt falls, high_len <= length counter and len_valid pulses for one cycle.
  - A pulse never completed (still high) does not update high_len.
- thresh_hit: combinational compare of the rise_count register; THRESH=0 makes it constantly 1 out of reset.
- clr (synchronous, en-independent):
  - Clears rise_count, sat, high_len and len_valid next edge.
  - Does not disturb the FSM, filt, the in-progress length counter or the edge pulses.
  - clr coincident with rise_pulse: clr wins, rise_count=0, rise_pulse still asserts.
  - clr coincident with a completing fall: high_len=0 and len_valid=0.
- en=0:
  - FSM, run counter, filt, counters and length counter hold.
  - din is ignored; rise_pulse, fall_pulse and len_valid are forced 0.
  - Resuming en=1 continues from the held state.
- Reset mid-operation: any pending or high state is dropped immediately; filt=0, no fall_pulse generated.

Test Plan (STABLE_CYCLES=2, CNT_W=4, THRESH=3 unless noted):
- Reset and glitch rejection: rst_n low 2 cycles, then din=1 for 1 cycle -> all outputs 0; filt stays 0, no rise_pulse.
- Clean pulse: din=1 for 6 cycles then 0 -> filt rises 2 edges after the first 1 sample, rise_pulse 1 cycle, rise_count=1; fall_pulse and len_valid 2 edges after the first 0, high_len=6.
- Threshold and saturation: 17 clean pulses -> thresh_hit asserts at the 3rd rise_pulse; rise_count sticks at 15 with sat=1 from the 15th rise onward.
- clr collision: assert clr in the rise_pulse cycle of the 2nd pulse -> rise_count=0, sat=0, thresh_hit=0, filt unaffected.
- en hold: deassert en while in P_HIGH with run=1 for 5 cycles, din toggling -> no change; re-enable with din=1 -> filt rises on the first enabled edge.
- Async reset mid-pulse: drop rst_n while filt=1 and the length counter is at 4 -> filt=0 immediately, no fall_pulse, high_len=0, len_valid=0.
